// File: rtl/twos_negate_serial.sv
// twos_negate_serial
//   Digit-serial two's-complement unit. It negates, takes the absolute value
//   of, or passes a WIDTH-bit signed operand. It handles DIGIT bits per clock,
//   least-significant digit first, through a registered carry.
//
//   The operand and the inversion decision are registered at acceptance.
//   Later changes on A/mode have no effect on the operation in flight.
//   out_valid rises exactly N = WIDTH/DIGIT edges after the accepting edge.
//   Y and ovf then hold until the consumer takes them.
//
//   Build option: define TWOS_SAT_EN to saturate an overflowing result to the
//   maximum positive value. Without it, the wrapped result (equal to A) is
//   returned. ovf is set in both builds.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   in_valid   A and mode are valid
//   in_ready   unit can accept an operand (IDLE only)
//   A          operand, signed two's complement, WIDTH bits
//   mode       00 pass, 01 negate, 10 abs, 11 pass
//   out_valid  Y and ovf are valid
//   out_ready  consumer accepts the result
//   Y          result, WIDTH bits
//   ovf        result not representable (A == MIN and inverted)
//
// States
//   IDLE | waiting for an operand, in_ready high
//   BUSY | one digit per cycle through the carry chain
//   DONE | result presented, held until out_ready
module twos_negate_serial #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Y,
  output logic             ovf
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0]    CNT_LOAD = CW'(N - 1);
  localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] MAX_VAL  = {1'b0, {(WIDTH-1){1'b1}}};

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic             inv_q;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic             inv_in;
  logic             ovf_in;
  logic [DIGIT:0]   sum;
  logic [WIDTH-1:0] y_shift;

  assign inv_in = (mode == 2'b01) | ((mode == 2'b10) & A[WIDTH-1]);
  assign ovf_in = inv_in & (A == MIN_VAL);

  // The current digit always sits in the low bits of a_sh. The conditional
  // one's complement plus the carry gives the two's complement when inv_q is set.
  assign sum = {1'b0, a_sh[DIGIT-1:0] ^ {DIGIT{inv_q}}} + {{DIGIT{1'b0}}, carry};

  // Result digits enter at the top and move down. After N steps, digit 0 is at the LSB.
  assign y_shift = (Y >> DIGIT) | (WIDTH'(sum[DIGIT-1:0]) << (WIDTH - DIGIT));

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      Y         <= '0;
      ovf       <= 1'b0;
      a_sh      <= '0;
      inv_q     <= 1'b0;
      carry     <= 1'b0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            a_sh     <= A;
            inv_q    <= inv_in;
            ovf      <= ovf_in;
            carry    <= inv_in;
            cnt      <= CNT_LOAD;
            in_ready <= 1'b0;
            state    <= BUSY;
          end
        end
        BUSY: begin
          a_sh  <= a_sh >> DIGIT;
          carry <= sum[DIGIT];
          Y     <= y_shift;
          if (cnt == '0) begin
            state     <= DONE;
            out_valid <= 1'b1;
`ifdef TWOS_SAT_EN
            if (ovf) Y <= MAX_VAL;
`endif
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_twos_negate_serial.sv
module tb_twos_negate_serial;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       out_ready;
  logic [7:0] A;
  logic [1:0] mode;

  logic       in_ready_a, out_valid_a, ovf_a;
  logic [7:0] Y_a;
  logic       in_ready_b, out_valid_b, ovf_b;
  logic [7:0] Y_b;

  always #5 clk = ~clk;

  twos_negate_serial #(.WIDTH(8), .DIGIT(2)) dut_a (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_a),
    .A(A), .mode(mode), .out_valid(out_valid_a), .out_ready(out_ready),
    .Y(Y_a), .ovf(ovf_a)
  );

  twos_negate_serial #(.WIDTH(8), .DIGIT(8)) dut_b (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_b),
    .A(A), .mode(mode), .out_valid(out_valid_b), .out_ready(out_ready),
    .Y(Y_b), .ovf(ovf_b)
  );

`ifdef TWOS_SAT_EN
  localparam logic [7:0] MIN_Y = 8'h7F;
`else
  localparam logic [7:0] MIN_Y = 8'h80;
`endif

  typedef struct {
    logic [1:0] mode;
    logic [7:0] a;
    logic [7:0] y;
    logic       ovf;
  } vec_t;

  vec_t vecs[12];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
  endtask

  // Runs one operation through both instances with out_ready held high.
  task automatic run_op(input int idx, input logic [1:0] m, input logic [7:0] a,
                        input logic [7:0] ey, input logic eovf);
    int         lat_a = -1;
    int         lat_b = -1;
    int         width_a = 0;
    logic [7:0] ya = '0;
    logic [7:0] yb = '0;
    logic       oa = 1'b0;
    logic       ob = 1'b0;
    string      tag;
    tag = $sformatf("vec%0d", idx);
    @(negedge clk);
    check({tag, " in_ready"}, {30'b0, in_ready_a, in_ready_b}, 32'd3);
    mode = m; A = a; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; A = ~a; mode = 2'b01;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      if (out_valid_a) begin
        if (lat_a < 0) begin lat_a = k; ya = Y_a; oa = ovf_a; end
        width_a++;
      end
      if (out_valid_b && lat_b < 0) begin lat_b = k; yb = Y_b; ob = ovf_b; end
    end
    check({tag, " latency_d2"}, lat_a, 32'd4);
    check({tag, " valid_width_d2"}, width_a, 32'd1);
    check({tag, " Y_d2"}, {24'b0, ya}, {24'b0, ey});
    check({tag, " ovf_d2"}, {31'b0, oa}, {31'b0, eovf});
    check({tag, " latency_d8"}, lat_b, 32'd1);
    check({tag, " Y_d8"}, {24'b0, yb}, {24'b0, ey});
    check({tag, " ovf_d8"}, {31'b0, ob}, {31'b0, eovf});
  endtask

  initial begin
    int seen;
    vecs[0]  = '{2'b01, 8'h05, 8'hFB, 1'b0};
    vecs[1]  = '{2'b10, 8'hF6, 8'h0A, 1'b0};
    vecs[2]  = '{2'b10, 8'h0A, 8'h0A, 1'b0};
    vecs[3]  = '{2'b01, 8'h80, MIN_Y, 1'b1};
    vecs[4]  = '{2'b10, 8'h80, MIN_Y, 1'b1};
    vecs[5]  = '{2'b11, 8'h3C, 8'h3C, 1'b0};
    vecs[6]  = '{2'b01, 8'h00, 8'h00, 1'b0};
    vecs[7]  = '{2'b00, 8'h80, 8'h80, 1'b0};
    vecs[8]  = '{2'b01, 8'h7F, 8'h81, 1'b0};
    vecs[9]  = '{2'b10, 8'hFF, 8'h01, 1'b0};
    vecs[10] = '{2'b01, 8'hFF, 8'h01, 1'b0};
    vecs[11] = '{2'b00, 8'hA5, 8'hA5, 1'b0};

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; A = '0; mode = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst in_ready", {30'b0, in_ready_a, in_ready_b}, 32'd0);
    check("rst out_valid", {30'b0, out_valid_a, out_valid_b}, 32'd0);
    check("rst Y", {16'b0, Y_a, Y_b}, 32'd0);
    check("rst ovf", {30'b0, ovf_a, ovf_b}, 32'd0);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    check("post-rst in_ready", {30'b0, in_ready_a, in_ready_b}, 32'd3);

    for (int i = 0; i < 12; i++)
      run_op(i, vecs[i].mode, vecs[i].a, vecs[i].y, vecs[i].ovf);

    // Result stalled in DONE: hold, refuse new operands, release.
    @(negedge clk);
    mode = 2'b01; A = 8'h80; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0; A = 8'h00;
    repeat (4) @(posedge clk);
    #1;
    check("stall out_valid rise", {31'b0, out_valid_a}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = (i == 2);
      A = 8'h11;
      @(posedge clk); #1;
      check($sformatf("stall%0d Y", i), {24'b0, Y_a}, {24'b0, MIN_Y});
      check($sformatf("stall%0d ovf/valid/rdy", i),
            {29'b0, ovf_a, out_valid_a, in_ready_a}, 32'd6);
    end
    @(negedge clk); in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    check("release in_ready", {31'b0, in_ready_a}, 32'd1);
    check("release out_valid", {31'b0, out_valid_a}, 32'd0);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (out_valid_a) seen++;
    end
    check("stall pulse not queued", seen, 32'd0);

    // Reset during the second BUSY cycle drops the operation.
    @(negedge clk);
    mode = 2'b01; A = 8'h05; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    check("midrst out_valid", {30'b0, out_valid_a, out_valid_b}, 32'd0);
    check("midrst Y", {16'b0, Y_a, Y_b}, 32'd0);
    check("midrst ovf", {31'b0, ovf_a}, 32'd0);
    check("midrst in_ready", {31'b0, in_ready_a}, 32'd0);
    @(posedge clk); #1;
    check("midrst in_ready held", {31'b0, in_ready_a}, 32'd0);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    check("midrst in_ready after", {31'b0, in_ready_a}, 32'd1);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (out_valid_a) seen++;
    end
    check("midrst no result", seen, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
